trdb_packet_serializer: RTL

- Sits directly upstream of the uDMA tracer adapter.
- Takes one complete trace packet per handshake, up to PACKET_WIDTH bits, and emits it as a framed stream of 16-bit words on a valid/ready interface. That interface drives the adapter's data_rx_data/data_rx_valid/data_rx_ready path.
- Each frame is one header word followed by the payload words, least-significant word first.
- Drops malformed packets and packets that arrive while disabled, and counts them.

---
 rtl/trdb_pkg.sv | 17 +
 rtl/trdb_sat_counter.sv | 24 ++
 rtl/trdb_packet_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared types and helpers for the trace packet serializer.
package trdb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } trdb_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [15:0] trdb_header(input logic [7:0] sync_byte,
                                              input logic [7:0] len);
    return {sync_byte, len};
  endfunction

endpackage

// File: rtl/trdb_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module trdb_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/trdb_packet_serializer.sv
// Frames one trace packet per handshake into a header word plus LSW-first
// 16-bit payload words; malformed or disabled-time packets are dropped and counted.
module trdb_packet_serializer
  import trdb_pkg::*;
#(
  parameter int         PACKET_WIDTH = 128,
  parameter int         LEN_WIDTH    = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clr_drop_i,
  input  logic [PACKET_WIDTH-1:0] packet_i,
  input  logic [LEN_WIDTH-1:0]    packet_len_i,
  input  logic                    packet_valid_i,
  output logic                    packet_ready_o,
  output logic [15:0]             data_o,
  output logic                    data_valid_o,
  input  logic                    data_ready_i,
  output logic                    busy_o,
  output logic [7:0]              drop_cnt_o
);

  localparam int unsigned NWORDS = PACKET_WIDTH / 16;

  trdb_state_e             state_q;
  logic [PACKET_WIDTH-1:0] pkt_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    idx_q;
  logic [15:0]             data_q;
  logic                    valid_q;

  logic [LEN_WIDTH:0] idx_inc_s;
  logic               last_s;
  logic               ready_s;
  logic               accept_s;
  logic               legal_s;
  logic               xfer_s;
  logic [15:0]        hdr_s;

  assign idx_inc_s = {1'b0, idx_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign last_s    = (idx_inc_s == {1'b0, len_q});
  assign legal_s   = enable_i && (packet_len_i != '0) && (32'(packet_len_i) <= NWORDS);
  assign accept_s  = packet_valid_i & ready_s;
  assign xfer_s    = valid_q & data_ready_i;
  assign hdr_s     = trdb_header(SYNC_BYTE, 8'(packet_len_i));

  // Ready depends only on state and downstream ready, never on packet_valid_i.
  always_comb begin
    ready_s = 1'b0;
    if (rst_i) begin
      ready_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    ready_s = 1'b1;
        PAYLOAD: ready_s = last_s & data_ready_i;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // Payload is kept in a shift register so the next word is always pkt_q[15:0].
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s && legal_s) begin
            pkt_q   <= packet_i;
            len_q   <= packet_len_i;
            idx_q   <= '0;
            data_q  <= hdr_s;
            valid_q <= 1'b1;
            state_q <= HEADER;
          end
        end
        HEADER: begin
          if (xfer_s) begin
            data_q  <= pkt_q[15:0];
            pkt_q   <= pkt_q >> 16;
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer_s) begin
            if (!last_s) begin
              idx_q  <= idx_inc_s[LEN_WIDTH-1:0];
              data_q <= pkt_q[15:0];
              pkt_q  <= pkt_q >> 16;
            end else if (accept_s && legal_s) begin
              pkt_q   <= packet_i;
              len_q   <= packet_len_i;
              idx_q   <= '0;
              data_q  <= hdr_s;
              valid_q <= 1'b1;
              state_q <= HEADER;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  trdb_sat_counter #(.WIDTH(8)) u_drop_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_drop_i),
    .inc_i   (accept_s & ~legal_s),
    .count_o (drop_cnt_o)
  );

  assign packet_ready_o = ready_s;
  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign busy_o         = (state_q != IDLE);

endmodule
